// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FFT constants and bit-reversal helper
package fft_pkg;

    localparam int N_DEFAULT     = 128;
    localparam int LANES         = 4;
    localparam int LOG2N         = $clog2(N_DEFAULT);
    localparam int NBITS_DEFAULT = 15;

    // Reverses the low 'width' bits of index; bits above width come back as zero.
    function automatic logic [31:0] bitrev(input logic [31:0] index, input int width);
        logic [31:0] r;
        logic [4:0]  k;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            k = 5'(width - 1 - i);
            if (i < width) r[i] = index[k];
        end
        return r;
    endfunction

endpackage

// File: rtl/reorder_bank.sv
// rtl/reorder_bank.sv - N-word bank, 4 scattered write ports, 4 consecutive read ports
module reorder_bank
    import fft_pkg::*;
#(
    parameter int N  = N_DEFAULT,
    parameter int W  = 2 * NBITS_DEFAULT,
    parameter int AW = $clog2(N)
) (
    input  logic                          clk,
    input  logic                          we,
    input  logic [LANES-1:0][AW-1:0]      waddr,
    input  logic [LANES-1:0][W-1:0]       wdata,
    input  logic [AW-3:0]                 rbase,
    output logic [LANES-1:0][W-1:0]       rdata
);

    logic [W-1:0] mem [N];

    // Storage is deliberately not reset; every word is rewritten before it is read.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int l = 0; l < LANES; l++) begin
                mem[waddr[l]] <= wdata[l];
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int j = 0; j < LANES; j++) begin
            rdata[j] = mem[{rbase, 2'(j)}];
        end
    end

endmodule

// File: rtl/fft_out_reorder.sv
// rtl/fft_out_reorder.sv - ping-pong bit-reversed to natural order reorder stage
module fft_out_reorder
    import fft_pkg::*;
#(
    parameter int NBITS = NBITS_DEFAULT,
    parameter int N     = N_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic                 in_sof,
    input  logic [2*NBITS-1:0]   in0_up,
    input  logic [2*NBITS-1:0]   in0_down,
    input  logic [2*NBITS-1:0]   in1_up,
    input  logic [2*NBITS-1:0]   in1_down,
    output logic                 out_valid,
    output logic                 out_sof,
    output logic [2*NBITS-1:0]   out0,
    output logic [2*NBITS-1:0]   out1,
    output logic [2*NBITS-1:0]   out2,
    output logic [2*NBITS-1:0]   out3
);

    localparam int W  = 2 * NBITS;
    localparam int AW = $clog2(N);
    localparam int BW = AW - 2;
    localparam logic [BW-1:0] LAST = BW'(N / 4 - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] READ = 1'b1;

    logic [0:0]                state;
    logic [BW-1:0]             wcnt;
    logic [BW-1:0]             rcnt;
    logic [BW-1:0]             t;
    logic                      wsel;
    logic                      complete;
    logic [LANES-1:0][AW-1:0]  waddr;
    logic [LANES-1:0][W-1:0]   wdata;
    logic [LANES-1:0][W-1:0]   rd0;
    logic [LANES-1:0][W-1:0]   rd1;
    logic [LANES-1:0][W-1:0]   rdata;

    // in_sof pins the beat to t = 0, silently dropping any partial frame.
    assign t        = in_sof ? '0 : wcnt;
    assign complete = in_valid && (t == LAST);
    assign wdata    = {in1_down, in1_up, in0_down, in0_up};
    assign rdata    = wsel ? rd0 : rd1;

    always_comb begin
        waddr = '0;
        for (int l = 0; l < LANES; l++) begin
            waddr[l] = AW'(bitrev(32'({t, 2'(l)}), AW));
        end
    end

    reorder_bank #(.N(N), .W(W), .AW(AW)) u_bank0 (
        .clk   (clk),
        .we    (in_valid && !wsel),
        .waddr (waddr),
        .wdata (wdata),
        .rbase (rcnt),
        .rdata (rd0)
    );

    reorder_bank #(.N(N), .W(W), .AW(AW)) u_bank1 (
        .clk   (clk),
        .we    (in_valid && wsel),
        .waddr (waddr),
        .wdata (wdata),
        .rbase (rcnt),
        .rdata (rd1)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            wcnt      <= '0;
            rcnt      <= '0;
            wsel      <= 1'b0;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out0      <= '0;
            out1      <= '0;
            out2      <= '0;
            out3      <= '0;
        end else begin
            if (in_valid) begin
                wcnt <= complete ? '0 : t + BW'(1);
            end
            if (complete) begin
                wsel <= ~wsel;
            end

            // A completion on the last read edge restarts the sequencer seamlessly.
            if (complete) begin
                state <= READ;
                rcnt  <= '0;
            end else if (state == READ) begin
                if (rcnt == LAST) state <= IDLE;
                rcnt <= rcnt + BW'(1);
            end

            if (state == READ) begin
                out_valid <= 1'b1;
                out_sof   <= (rcnt == '0);
                out0      <= rdata[0];
                out1      <= rdata[1];
                out2      <= rdata[2];
                out3      <= rdata[3];
            end else begin
                out_valid <= 1'b0;
                out_sof   <= 1'b0;
            end
        end
    end

endmodule

// File: doc/fft_out_reorder.md
# fft_out_reorder

Output reorder stage for the 4-parallel pipelined FFT. It accepts the four saturated complex lanes produced by the FFT core in bit-reversed order, four bins per clock. It buffers each frame in a ping-pong memory and emits the same frame in natural bin order, four consecutive bins per clock. It sits directly after the saturation stage and is the reading end of the FFT core's output ordering.

## Interface
Parameters:
- NBITS, 15: bits per real/imag component (Q3.12, matches core saturation output).
- N, 128: FFT size in bins. Power of two, ≥16.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk  in  1  system clock.
  - rst  in  1  asynchronous, active-low reset.
- Input data and framing:
  - in_valid  in  1  the four input lanes carry valid data this cycle.
  - in_sof  in  1  with in_valid, this beat is beat 0 of a frame.
  - in0_up, in0_down, in1_up, in1_down  in  2*NBITS each  input lanes 0..3, {re, im}, re in the MSBs.
- Output data and framing:
  - out_valid  out  1  output lanes valid.
  - out_sof  out  1  first beat of an output frame.
  - out0, out1, out2, out3  out  2*NBITS each  natural-order bins 4c+0 .. 4c+3, {re, im}.

## Operation
- A frame is N/4 accepted beats, with beat index t = 0..N/4-1.
- Lane l (0 = in0_up, 1 = in0_down, 2 = in1_up, 3 = in1_down) at beat t carries bin bitrev_log2N(4t+l).
- Write counter wcnt:
  - Advances on each in_valid beat and wraps from N/4-1 to 0.
  - in_sof with in_valid forces that beat to t = 0. Any partial frame in the write bank is abandoned, with no swap and no output.
- Ping-pong memory: two banks of N words, each 2*NBITS wide.
  - Each beat writes 4 words of the write bank at addresses bitrev(4t+l).
- Frame completion: the beat with t = N/4-1 completes the frame.
  - On that edge the write and read banks swap, and the read sequencer starts.
- Read FSM has two states, IDLE and READ.
  - IDLE→READ on frame completion, with rcnt = 0.
  - In READ, each cycle loads out_j ← bank[4*rcnt+j] into the output registers, then increments rcnt.
  - After rcnt = N/4-1: go to IDLE, or restart at rcnt = 0 if another frame completed on the same edge.
- Output has no backpressure. The data path is bit-exact pass-through, with no rounding and no sign change.
- Overflow cannot occur: a frame takes ≥N/4 cycles to write and exactly N/4 cycles to read.

## Timing
- Reset (rst = 0, asynchronous): all outputs are 0, out_valid = out_sof = 0, wcnt = rcnt = 0, bank select = 0, FSM in IDLE.
  - Memory contents are not reset.
- Latency: the first natural-order beat (bins 0..3) appears, registered, one cycle after the edge that accepts beat N/4-1.
- out_valid stays high for exactly N/4 consecutive cycles per frame. out_sof is high only on the first of those cycles.
- Back-to-back frames with in_valid held high give continuous output:
  - The last read of frame A and the completion of frame B share an edge.
  - out_valid stays high with no bubble, and out_sof pulses every N/4 cycles.
- in_valid gaps only delay frame completion. Output timing is relative to the completing beat.
- in_sof asserted at t = 0 when the counter is already at 0 is a no-op resync.
- Reset mid-frame or mid-output: output clears immediately. After release, the first frame starts at the first in_valid beat.

## Structure
- Shared package fft_pkg: N default, LANES = 4, LOG2N, the bitrev(index, width) function, and the NBITS default for output samples.
- One sub-module, reorder_bank: a single N×2*NBITS bank with 4 write ports at arbitrary addresses and 4 read ports at consecutive addresses 4c..4c+3.
- The top level instantiates two reorder_bank instances plus the counters, bank select and read FSM.

## Test plan
- Reset: hold rst = 0 with random inputs. Required: all outputs 0 and out_valid = 0. After release, outputs stay 0 until a frame completes.
- Single frame, N = 128: drive 32 beats where lane l at beat t carries re = bitrev7(4t+l), im = -re. Required: out_valid high on the cycle after beat 31 for 32 cycles, cycle c gives out_j.re = 4c+j, and out_sof only at c = 0.
- Back-to-back: two frames with in_valid continuous. Required: out_valid high for 64 consecutive cycles, out_sof at output cycles 0 and 32, and the second frame's data correct.
- Gapped input: in_valid on alternate cycles. Required: identical data, with the first output one cycle after the 32nd accepted beat.
- Resync: in_sof at beat 10 of a frame, then a full 32-beat frame. Required: exactly one output frame, containing the full frame's data.
- Reset mid-output: pull rst low at output cycle 12. Required: outputs and out_valid are 0 asynchronously. After release, a new frame produces correct output.
